// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-ported architectural register file with a per-register
//                busy scoreboard. Writes land at the clock edge (highest port
//                wins on collisions), reads are registered with one cycle of
//                latency and bypass same-cycle writes, and register 0 is
//                hardwired to zero and never busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2,
   parameter int RA   = $clog2(NREG),
   parameter int CW   = $clog2(NREG + 1)
) (
   input  logic                clk,
   input  logic                rst,
   // write ports
   input  logic [NWR-1:0]      we_i,
   input  logic [NWR*RA-1:0]   sel_rd_i,
   input  logic [NWR*XLEN-1:0] rd_i,
   // read ports
   input  logic [NRD-1:0]      re_i,
   input  logic [NRD*RA-1:0]   sel_rs_i,
   output logic [NRD*XLEN-1:0] rs_o,
   output logic [NRD-1:0]      rs_busy_o,
   // scoreboard
   input  logic                alloc_i,
   input  logic [RA-1:0]       alloc_sel_i,
   output logic [CW-1:0]       busy_cnt_o
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] busy_q;
   logic [CW-1:0]   busy_cnt_q;
   logic [NRD*XLEN-1:0] rs_q;
   logic [NRD-1:0]      rs_busy_q;

   // -------------------------------------------------------------------------
   // Next-state / combinational signals
   // -------------------------------------------------------------------------
   logic [RA-1:0]   w_sel_rd [NWR];
   logic [XLEN-1:0] w_rd     [NWR];
   logic [RA-1:0]   w_sel_rs [NRD];

   logic [NREG-1:0] w_wen;             // register r is written this cycle
   logic [XLEN-1:0] w_wdata [NREG];    // winning write data for register r
   logic [XLEN-1:0] regs_d  [NREG];    // register contents after this edge
   logic [NREG-1:0] busy_d;
   logic [CW-1:0]   busy_cnt_d;
   logic [XLEN-1:0] rs_d      [NRD];
   logic [NRD-1:0]  rs_busy_d;

   // -------------------------------------------------------------------------
   // Unpack the flat per-port buses into arrays
   // -------------------------------------------------------------------------
   genvar gk;
   generate
      for (gk = 0; gk < NWR; gk++) begin : g_wr_unpack
         assign w_sel_rd[gk] = sel_rd_i[gk*RA +: RA];
         assign w_rd[gk]     = rd_i[gk*XLEN +: XLEN];
      end
      for (gk = 0; gk < NRD; gk++) begin : g_rd_unpack
         assign w_sel_rs[gk] = sel_rs_i[gk*RA +: RA];
      end
   endgenerate

   // Resolve write ports per register; later (higher) ports overwrite earlier
   // ones so the highest-numbered enabled port wins a collision.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         w_wen[r]   = 1'b0;
         w_wdata[r] = '0;
      end
      for (int k = 0; k < NWR; k++) begin
         if (we_i[k] && (w_sel_rd[k] != '0)) begin
            w_wen[w_sel_rd[k]]   = 1'b1;
            w_wdata[w_sel_rd[k]] = w_rd[k];
         end
      end
   end

   // Post-edge register image; also serves as the bypass source for reads.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         if (r == 0) begin
            regs_d[r] = '0;
         end else if (w_wen[r]) begin
            regs_d[r] = w_wdata[r];
         end else begin
            regs_d[r] = regs_q[r];
         end
      end
   end

   // Scoreboard next state: writes clear, allocation sets and takes priority.
   always_comb begin
      busy_d = busy_q & ~w_wen;
      if (alloc_i && (alloc_sel_i != '0)) begin
         busy_d[alloc_sel_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Population count of the next-state busy bits.
   always_comb begin
      busy_cnt_d = '0;
      for (int r = 0; r < NREG; r++) begin
         busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
      end
   end

   // Read port lookup against the post-edge image (write bypass built in).
   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         rs_d[p]      = regs_d[w_sel_rs[p]];
         rs_busy_d[p] = busy_d[w_sel_rs[p]];
      end
   end

   // -------------------------------------------------------------------------
   // Sequential logic
   // -------------------------------------------------------------------------

   // Register array and scoreboard update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
         end
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Per-port registered read data and busy flag; held while re_i is low.
   generate
      for (gk = 0; gk < NRD; gk++) begin : g_rd_port
         always_ff @(posedge clk) begin
            if (rst) begin
               rs_q[gk*XLEN +: XLEN] <= '0;
               rs_busy_q[gk]         <= 1'b0;
            end else if (re_i[gk]) begin
               rs_q[gk*XLEN +: XLEN] <= rs_d[gk];
               rs_busy_q[gk]         <= rs_busy_d[gk];
            end
         end
      end
   endgenerate

   assign rs_o       = rs_q;
   assign rs_busy_o  = rs_busy_q;
   assign busy_cnt_o = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed self-checking bench for regfile_mp
//                (XLEN=32, NREG=32, NRD=2, NWR=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int RA   = 5;
   localparam int CW   = 6;

   logic                clk = 1'b0;
   logic                rst;
   logic [NWR-1:0]      we_i;
   logic [NWR*RA-1:0]   sel_rd_i;
   logic [NWR*XLEN-1:0] rd_i;
   logic [NRD-1:0]      re_i;
   logic [NRD*RA-1:0]   sel_rs_i;
   logic [NRD*XLEN-1:0] rs_o;
   logic [NRD-1:0]      rs_busy_o;
   logic                alloc_i;
   logic [RA-1:0]       alloc_sel_i;
   logic [CW-1:0]       busy_cnt_o;

   int tests = 0;
   int fails = 0;

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we_i),
      .sel_rd_i    (sel_rd_i),
      .rd_i        (rd_i),
      .re_i        (re_i),
      .sel_rs_i    (sel_rs_i),
      .rs_o        (rs_o),
      .rs_busy_o   (rs_busy_o),
      .alloc_i     (alloc_i),
      .alloc_sel_i (alloc_sel_i),
      .busy_cnt_o  (busy_cnt_o)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we_i = '0; sel_rd_i = '0; rd_i = '0;
      re_i = '0; sel_rs_i = '0;
      alloc_i = 1'b0; alloc_sel_i = '0;
   endtask

   task automatic wr(input int k, input logic [RA-1:0] idx, input logic [XLEN-1:0] d);
      we_i[k] = 1'b1;
      sel_rd_i[k*RA +: RA] = idx;
      rd_i[k*XLEN +: XLEN] = d;
   endtask

   task automatic rd(input int p, input logic [RA-1:0] idx);
      re_i[p] = 1'b1;
      sel_rs_i[p*RA +: RA] = idx;
   endtask

   function automatic logic [XLEN-1:0] rs(input int p);
      return rs_o[p*XLEN +: XLEN];
   endfunction

   task automatic test_reset();
      logic [XLEN-1:0] v;
      idle();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         wr(0, RA'($urandom_range(1, 31)), $urandom);
         wr(1, RA'($urandom_range(1, 31)), $urandom);
         alloc_i = 1'b1; alloc_sel_i = RA'($urandom_range(1, 31));
         rd(0, RA'($urandom_range(1, 31))); rd(1, RA'($urandom_range(1, 31)));
         tick();
      end
      for (int p = 0; p < NRD; p++) begin
         tests++; v = rs(p);
         if (v !== '0) begin fails++; $display("FAIL reset_rs%0d got %h want 0", p, v); end
      end
      tests++;
      if (rs_busy_o !== '0) begin fails++; $display("FAIL reset_busy got %b want 0", rs_busy_o); end
      tests++;
      if (busy_cnt_o !== '0) begin fails++; $display("FAIL reset_cnt got %0d want 0", busy_cnt_o); end
      rst = 1'b0; idle();
      rd(0, 5'd5);
      tick();
      tests++; v = rs(0);
      if (v !== '0) begin fails++; $display("FAIL reset_read_x5 got %h want 0", v); end
      idle();
   endtask

   task automatic test_write_bypass();
      logic [XLEN-1:0] v;
      idle();
      wr(0, 5'd5, 32'hDEADBEEF);
      rd(0, 5'd5); rd(1, 5'd5);
      tick();
      tests++; v = rs(0);
      if (v !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_p0 got %h want deadbeef", v); end
      tests++; v = rs(1);
      if (v !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_p1 got %h want deadbeef", v); end
      idle(); rd(0, 5'd5); rd(1, 5'd0);
      tick();
      tests++; v = rs(0);
      if (v !== 32'hDEADBEEF) begin fails++; $display("FAIL stored_x5 got %h want deadbeef", v); end
      tests++; v = rs(1);
      if (v !== '0) begin fails++; $display("FAIL read_x0 got %h want 0", v); end
      idle();
   endtask

   task automatic test_collision_x0();
      logic [XLEN-1:0] v;
      idle();
      wr(0, 5'd7, 32'h1111); wr(1, 5'd7, 32'h2222);
      tick();
      idle(); rd(1, 5'd7);
      tick();
      tests++; v = rs(1);
      if (v !== 32'h2222) begin fails++; $display("FAIL collision_x7 got %h want 2222", v); end
      // Collision seen through the bypass path as well.
      idle(); wr(0, 5'd8, 32'hAAAA); wr(1, 5'd8, 32'hBBBB); rd(0, 5'd8);
      tick();
      tests++; v = rs(0);
      if (v !== 32'hBBBB) begin fails++; $display("FAIL collision_bypass_x8 got %h want bbbb", v); end
      idle(); wr(1, 5'd0, 32'hFFFFFFFF); rd(0, 5'd0);
      tick();
      idle(); rd(0, 5'd0);
      tick();
      tests++; v = rs(0);
      if (v !== '0) begin fails++; $display("FAIL write_x0 got %h want 0", v); end
      idle();
   endtask

   task automatic test_scoreboard();
      idle(); alloc_i = 1'b1; alloc_sel_i = 5'd3; rd(0, 5'd3);
      tick();
      tests++;
      if (rs_busy_o[0] !== 1'b1) begin fails++; $display("FAIL sb_busy_x3 got %b want 1", rs_busy_o[0]); end
      tests++;
      if (busy_cnt_o !== 6'd1) begin fails++; $display("FAIL sb_cnt_a3 got %0d want 1", busy_cnt_o); end
      idle(); alloc_i = 1'b1; alloc_sel_i = 5'd4;
      tick();
      tests++;
      if (busy_cnt_o !== 6'd2) begin fails++; $display("FAIL sb_cnt_a4 got %0d want 2", busy_cnt_o); end
      // Re-allocating a busy register changes nothing.
      idle(); alloc_i = 1'b1; alloc_sel_i = 5'd3;
      tick();
      tests++;
      if (busy_cnt_o !== 6'd2) begin fails++; $display("FAIL sb_realloc got %0d want 2", busy_cnt_o); end
      idle(); wr(0, 5'd3, 32'h33); rd(0, 5'd3);
      tick();
      tests++;
      if (rs_busy_o[0] !== 1'b0) begin fails++; $display("FAIL sb_clear_x3 got %b want 0", rs_busy_o[0]); end
      tests++;
      if (busy_cnt_o !== 6'd1) begin fails++; $display("FAIL sb_cnt_w3 got %0d want 1", busy_cnt_o); end
      idle(); alloc_i = 1'b1; alloc_sel_i = 5'd4; wr(1, 5'd4, 32'h44); rd(1, 5'd4);
      tick();
      tests++;
      if (rs_busy_o[1] !== 1'b1) begin fails++; $display("FAIL sb_alloc_wins got %b want 1", rs_busy_o[1]); end
      tests++;
      if (busy_cnt_o !== 6'd1) begin fails++; $display("FAIL sb_cnt_aw4 got %0d want 1", busy_cnt_o); end
      tests++;
      if (rs(1) !== 32'h44) begin fails++; $display("FAIL sb_data_x4 got %h want 44", rs(1)); end
      // Allocating x0 is ignored.
      idle(); alloc_i = 1'b1; alloc_sel_i = 5'd0; rd(0, 5'd0);
      tick();
      tests++;
      if (rs_busy_o[0] !== 1'b0 || busy_cnt_o !== 6'd1) begin
         fails++; $display("FAIL sb_alloc_x0 got busy %b cnt %0d want 0 1", rs_busy_o[0], busy_cnt_o);
      end
      idle();
   endtask

   task automatic test_hold();
      idle(); wr(0, 5'd9, 32'h55);
      tick();
      idle(); rd(0, 5'd9);
      tick();
      tests++;
      if (rs(0) !== 32'h55) begin fails++; $display("FAIL hold_first got %h want 55", rs(0)); end
      idle(); wr(0, 5'd9, 32'h66); sel_rs_i[0 +: RA] = 5'd9;
      tick();
      tests++;
      if (rs(0) !== 32'h55) begin fails++; $display("FAIL hold_c1 got %h want 55", rs(0)); end
      idle(); sel_rs_i[0 +: RA] = 5'd7;
      tick();
      tests++;
      if (rs(0) !== 32'h55) begin fails++; $display("FAIL hold_c2 got %h want 55", rs(0)); end
      idle(); rd(0, 5'd9);
      tick();
      tests++;
      if (rs(0) !== 32'h66) begin fails++; $display("FAIL hold_resume got %h want 66", rs(0)); end
      idle();
   endtask

   task automatic test_mid_reset();
      // x4 is still busy from the scoreboard test; add x10 and x11.
      idle(); alloc_i = 1'b1; alloc_sel_i = 5'd10; wr(0, 5'd10, 32'hA0);
      tick();
      idle(); alloc_i = 1'b1; alloc_sel_i = 5'd11; wr(0, 5'd11, 32'hB0);
      tick();
      tests++;
      if (busy_cnt_o !== 6'd3) begin fails++; $display("FAIL mr_pre_cnt got %0d want 3", busy_cnt_o); end
      idle(); rst = 1'b1; alloc_i = 1'b1; alloc_sel_i = 5'd12;
      wr(1, 5'd12, 32'hC0); rd(0, 5'd10); rd(1, 5'd12);
      tick();
      rst = 1'b0;
      tests++;
      if (busy_cnt_o !== '0) begin fails++; $display("FAIL mr_cnt got %0d want 0", busy_cnt_o); end
      tests++;
      if (rs_o !== '0 || rs_busy_o !== '0) begin
         fails++; $display("FAIL mr_outputs got %h %b want 0 0", rs_o, rs_busy_o);
      end
      // First edge after reset behaves normally.
      idle(); rd(0, 5'd10); rd(1, 5'd12); alloc_i = 1'b1; alloc_sel_i = 5'd12;
      tick();
      tests++;
      if (rs(0) !== '0 || rs(1) !== '0) begin
         fails++; $display("FAIL mr_regs got %h %h want 0 0", rs(0), rs(1));
      end
      tests++;
      if (rs_busy_o !== 2'b10 || busy_cnt_o !== 6'd1) begin
         fails++; $display("FAIL mr_after got busy %b cnt %0d want 10 1", rs_busy_o, busy_cnt_o);
      end
      idle(); rd(0, 5'd4); rd(1, 5'd9);
      tick();
      tests++;
      if (rs(0) !== '0 || rs(1) !== '0) begin
         fails++; $display("FAIL mr_regs2 got %h %h want 0 0", rs(0), rs(1));
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      test_reset();
      test_write_bypass();
      test_collision_x0();
      test_scoreboard();
      test_hold();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of each register in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers; a power of two and at least 2; register 0 is hardwired to zero.
REQ-003 Parameter NRD, default 2, number of read ports; at least 1.
REQ-004 Parameter NWR, default 2, number of write ports; at least 1.
REQ-005 The derived width RA is $clog2(NREG) and the derived width CW is $clog2(NREG+1).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 we_i  in  NWR  per-port write enable.
REQ-009 sel_rd_i  in  NWR*RA  per-port destination index; port k occupies bits [k*RA +: RA].
REQ-010 rd_i  in  NWR*XLEN  per-port write data; port k occupies bits [k*XLEN +: XLEN].
REQ-011 re_i  in  NRD  per-port read enable.
REQ-012 sel_rs_i  in  NRD*RA  per-port source index.
REQ-013 rs_o  out  NRD*XLEN  per-port registered read data.
REQ-014 rs_busy_o  out  NRD  per-port registered scoreboard busy flag for the register being read.
REQ-015 alloc_i  in  1  marks register alloc_sel_i as having a pending producer.
REQ-016 alloc_sel_i  in  RA  index of the register being allocated.
REQ-017 busy_cnt_o  out  CW  registered count of registers currently marked busy.

Function
REQ-018 A write by port k with we_i[k]=1 and a nonzero destination index shall update that register at the clock edge; writes to index 0 shall be discarded.
REQ-019 When more than one enabled write port targets the same nonzero index in one cycle, the highest-numbered port shall win.
REQ-020 Register 0 shall read as 0 at all times, and its busy bit shall always be 0.
REQ-021 Read latency shall be exactly 1 cycle: with re_i[p]=1 at edge N, rs_o[p] shall present the data of register sel_rs_i[p] after edge N.
REQ-022 The read data shall be write-bypassed: if any enabled write in the same cycle targets the read index (nonzero), rs_o[p] shall take the winning write data, not the old register contents.
REQ-023 With re_i[p]=0, rs_o[p] and rs_busy_o[p] shall hold their previous values.
REQ-024 The scoreboard shall hold one busy bit per register: alloc_i with a nonzero alloc_sel_i shall set the bit, and any enabled write to that index shall clear it.
REQ-025 When alloc_i and a write target the same register in the same cycle, allocation shall win, so the bit ends at 1 and the data is still written.
REQ-026 Allocating a register that is already busy shall leave the bit at 1 and shall not be an error.
REQ-027 rs_busy_o[p] shall reflect the next-state busy bit of sel_rs_i[p] after that cycle's allocate and clear, consistent with the bypass in REQ-022.
REQ-028 busy_cnt_o shall equal the population count of the next-state busy bits, registered; its range is 0 to NREG-1.
REQ-029 Read ports shall be independent, and any number of them may address the same register in the same cycle.

Reset
REQ-030 When rst=1 at a clock edge, all registers shall become 0, all busy bits 0, rs_o 0, rs_busy_o 0 and busy_cnt_o 0; writes, allocations and reads in that cycle shall be ignored.
REQ-031 Reset asserted mid-operation shall take effect at the next edge, with no partial update surviving; the first edge after rst deasserts shall behave normally.

Verification (XLEN=32, NREG=32, NRD=2, NWR=2)
REQ-032 Reset: hold rst=1 for 2 cycles with random writes and allocations -> every rs_o=0, rs_busy_o=0 and busy_cnt_o=0; then a read of x5 returns 0.
REQ-033 Write and bypass: port0 writes x5=0xDEADBEEF and read port 0 reads x5 in the same cycle -> rs_o[0]=0xDEADBEEF one cycle later; the next-cycle read also returns 0xDEADBEEF.
REQ-034 Collision and x0: both ports write x7 (port0 0x1111, port1 0x2222) -> a read of x7 gives 0x2222; a write of 0xFFFFFFFF to x0 -> a read of x0 gives 0.
REQ-035 Scoreboard: alloc x3 -> rs_busy_o=1 and busy_cnt_o=1; alloc x4 -> count 2; write x3 -> count 1; alloc and write x4 in the same cycle -> x4 busy and count stays 1.
REQ-036 Hold: read x9=0x55 with re=1, then write x9=0x66 while re=0 -> rs_o holds 0x55 until re returns to 1, then shows 0x66.
REQ-037 Mid-operation reset: with 3 registers busy, assert rst for 1 cycle coincident with an alloc -> busy_cnt_o=0 and all registers read 0.
